// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   state_t     : receiver FSM states
//   PAR_*       : parity_type encodings (00/11 none, 01 odd, 10 even)
//   par_enabled : true when a parity bit follows the payload
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  localparam logic [1:0] PAR_NONE0 = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_EVEN  = 2'b10;
  localparam logic [1:0] PAR_NONE1 = 2'b11;

  function automatic logic par_enabled(input logic [1:0] pt);
    return (pt == PAR_ODD) || (pt == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line.
//   clk   : destination clock
//   reset : synchronous, active-high; both flops reset to 1 (idle line)
//   d     : asynchronous input
//   q     : synchronized output
module uart_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sipo_rx.sv
// UART receive deserializer, 16x (OVERSAMPLE) oversampled.
// Detects a start bit, shifts DATA_WIDTH bits in LSB first, checks optional
// parity and the stop bit, then presents the word with done/error flags.
//   baud_clk     : OVERSAMPLE x baud rate
//   reset        : synchronous, active-high
//   parity_type  : 00/11 none, 01 odd, 10 even; latched at start confirm
//   data_rx      : serial line, idle high, asynchronous
//   data_parll   : last received word, held until the next done_flag
//   active_flag  : high from start confirm through stop sample
//   done_flag    : one-cycle pulse when a frame completes
//   parity_error : parity result of the last frame
//   stop_error   : framing error of the last frame (stop bit sampled low)
module sipo_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  baud_clk,
  input  logic                  reset,
  input  logic [1:0]            parity_type,
  input  logic                  data_rx,
  output logic [DATA_WIDTH-1:0] data_parll,
  output logic                  active_flag,
  output logic                  done_flag,
  output logic                  parity_error,
  output logic                  stop_error
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  state_t                state, state_nx;
  logic                  rx_s;
  logic [TW-1:0]         tick_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [1:0]            par_lat;
  logic                  par_bit;
  logic                  mid_tick, end_tick, last_bit;
  logic                  par_bad;

  uart_sync2 u_sync (
    .clk   (baud_clk),
    .reset (reset),
    .d     (data_rx),
    .q     (rx_s)
  );

  assign mid_tick = (tick_cnt == TW'(OVERSAMPLE/2 - 1));
  assign end_tick = (tick_cnt == TW'(OVERSAMPLE - 1));
  assign last_bit = (bit_cnt == BW'(DATA_WIDTH - 1));

  // par_lat only selects odd/even when a parity bit was actually received.
  always_comb begin
    par_bad = 1'b0;
    if (par_lat == PAR_ODD)  par_bad = ~(^{shreg, par_bit});
    if (par_lat == PAR_EVEN) par_bad =   ^{shreg, par_bit};
  end

  // State register plus counters / datapath
  always_ff @(posedge baud_clk) begin
    if (reset) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      par_lat      <= PAR_NONE0;
      par_bit      <= 1'b0;
      data_parll   <= '0;
      done_flag    <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
    end else begin
      state     <= state_nx;
      done_flag <= 1'b0;
      case (state)
        IDLE, WAIT_HIGH: begin
          tick_cnt <= '0;
          bit_cnt  <= '0;
        end
        START: begin
          if (mid_tick) begin
            tick_cnt <= '0;
            par_lat  <= parity_type;
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        DATA: begin
          if (end_tick) begin
            shreg[bit_cnt] <= rx_s;
            tick_cnt       <= '0;
            bit_cnt        <= last_bit ? '0 : bit_cnt + BW'(1);
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        PARITY: begin
          if (end_tick) begin
            par_bit  <= rx_s;
            tick_cnt <= '0;
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        STOP: begin
          if (end_tick) begin
            data_parll   <= shreg;
            parity_error <= par_bad;
            stop_error   <= ~rx_s;
            done_flag    <= 1'b1;
            tick_cnt     <= '0;
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        default: tick_cnt <= '0;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (!rx_s) state_nx = START;
      // A line that is high again at mid-bit was a glitch.
      START:     if (mid_tick) state_nx = rx_s ? IDLE : DATA;
      DATA:      if (end_tick && last_bit)
                   state_nx = par_enabled(par_lat) ? PARITY : STOP;
      PARITY:    if (end_tick) state_nx = STOP;
      STOP:      if (end_tick) state_nx = rx_s ? IDLE : WAIT_HIGH;
      // A break must go high before another start can be seen.
      WAIT_HIGH: if (rx_s) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    active_flag = (state == DATA) || (state == PARITY) || (state == STOP);
  end

endmodule
